// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the 8-bit internal CPU bus: lane width, lane order and
// the serialiser state encoding.
package cpu_bus_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } lane_order_t;

  typedef enum logic {
    IDLE,
    SEND
  } ser_state_t;

endpackage

// File: rtl/byte_lane_select.sv
// Combinational lane picker: returns lane `lane` of `word`, zero for any index
// past the last lane so the select can never read outside the word.
module byte_lane_select #(
  parameter int  DATA_W = 16,
  parameter int  BYTE_W = cpu_bus_pkg::BYTE_W,
  localparam int LANES  = DATA_W / BYTE_W,
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [DATA_W-1:0] word,
  input  logic [LANE_W-1:0] lane,
  output logic [BYTE_W-1:0] lane_byte
);

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    lane_byte = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane == LANE_W'(i)) lane_byte = word[i*BYTE_W +: BYTE_W];
    end
  end

endmodule

// File: rtl/word_byte_serializer.sv
// Splits a DATA_W-bit word into BYTE_W-bit lanes over valid/ready, MSB- or
// LSB-first per word, with zero-bubble back-to-back words.
module word_byte_serializer #(
  parameter int  DATA_W = 16,
  parameter int  BYTE_W = cpu_bus_pkg::BYTE_W,
  localparam int LANES  = DATA_W / BYTE_W,
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_msb_first,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic [LANE_W-1:0] out_lane,
  output logic              out_last,
  output logic              busy
);

  import cpu_bus_pkg::*;

  if ((DATA_W < BYTE_W) || ((DATA_W % BYTE_W) != 0)) begin : g_bad_width
    $error("word_byte_serializer: DATA_W must be a non-zero multiple of BYTE_W");
  end

  localparam logic [LANE_W-1:0] TOP_LANE = LANE_W'(LANES - 1);

  ser_state_t               state_q, state_d;
  logic        [DATA_W-1:0] word_q, word_d;
  lane_order_t              order_q, order_d;
  logic                     valid_d, last_d;
  logic        [LANE_W-1:0] lane_d;
  logic        [BYTE_W-1:0] data_d;
  logic        [DATA_W-1:0] sel_word;
  logic        [LANE_W-1:0] sel_lane;
  logic        [BYTE_W-1:0] sel_byte;
  logic                     accept, xfer, advance;

  function automatic logic lane_is_last(input logic [LANE_W-1:0] lane,
                                        input lane_order_t order);
    return (order == MSB_FIRST) ? (lane == '0) : (lane == TOP_LANE);
  endfunction

  // Reset holds in_ready low so no word is taken while the block is cleared.
  assign xfer     = out_valid & out_ready;
  assign in_ready = rst_n & ((state_q == IDLE) | (xfer & out_last));
  assign accept   = in_valid & in_ready;
  assign advance  = xfer & ~out_last;
  assign busy     = out_valid;

  always_comb begin
    sel_word = word_q;
    sel_lane = out_lane;
    if (accept) begin
      sel_word = in_data;
      sel_lane = in_msb_first ? TOP_LANE : '0;
    end else if (advance) begin
      sel_lane = (order_q == MSB_FIRST) ? out_lane - LANE_W'(1) : out_lane + LANE_W'(1);
    end
  end

  byte_lane_select #(
    .DATA_W (DATA_W),
    .BYTE_W (BYTE_W)
  ) u_lane_select (
    .word      (sel_word),
    .lane      (sel_lane),
    .lane_byte (sel_byte)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    order_d = order_q;
    valid_d = out_valid;
    lane_d  = out_lane;
    data_d  = out_data;
    last_d  = out_last;
    if (accept) begin
      state_d = SEND;
      word_d  = in_data;
      order_d = lane_order_t'(in_msb_first);
      valid_d = 1'b1;
    end else if (xfer && out_last) begin
      state_d = IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
    if (accept || advance) begin
      lane_d = sel_lane;
      data_d = sel_byte;
      last_d = lane_is_last(sel_lane, order_d);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      word_q    <= '0;
      order_q   <= LSB_FIRST;
      out_valid <= 1'b0;
      out_lane  <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      order_q   <= order_d;
      out_valid <= valid_d;
      out_lane  <= lane_d;
      out_data  <= data_d;
      out_last  <= last_d;
    end
  end

endmodule

// File: tb/tb_word_byte_serializer.sv
// Directed bench for word_byte_serializer: 16-bit and 32-bit instances checked
// against hand-computed byte/lane/last sequences.
module tb_word_byte_serializer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_in_msb_first;
  logic [15:0] a_in_data;
  logic        a_out_valid, a_out_ready, a_out_last, a_busy;
  logic [7:0]  a_out_data;
  logic [0:0]  a_out_lane;

  logic        b_in_valid, b_in_ready, b_in_msb_first;
  logic [31:0] b_in_data;
  logic        b_out_valid, b_out_ready, b_out_last, b_busy;
  logic [7:0]  b_out_data;
  logic [1:0]  b_out_lane;

  word_byte_serializer #(.DATA_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_msb_first(a_in_msb_first), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_lane(a_out_lane), .out_last(a_out_last), .busy(a_busy)
  );

  word_byte_serializer #(.DATA_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_msb_first(b_in_msb_first), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_lane(b_out_lane), .out_last(b_out_last), .busy(b_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect16(input string tag, input logic [31:0] data, input logic [31:0] lane,
                          input logic [31:0] last, input logic [31:0] rdy);
    check({tag, "_valid"}, 32'(a_out_valid), 1);
    check({tag, "_data"},  32'(a_out_data),  data);
    check({tag, "_lane"},  32'(a_out_lane),  lane);
    check({tag, "_last"},  32'(a_out_last),  last);
    check({tag, "_busy"},  32'(a_busy),      1);
    check({tag, "_rdy"},   32'(a_in_ready),  rdy);
  endtask

  task automatic idle16(input string tag);
    check({tag, "_valid"}, 32'(a_out_valid), 0);
    check({tag, "_busy"},  32'(a_busy),      0);
    check({tag, "_rdy"},   32'(a_in_ready),  1);
  endtask

  task automatic expect32(input string tag, input logic [31:0] data, input logic [31:0] lane,
                          input logic [31:0] last);
    check({tag, "_valid"}, 32'(b_out_valid), 1);
    check({tag, "_data"},  32'(b_out_data),  data);
    check({tag, "_lane"},  32'(b_out_lane),  lane);
    check({tag, "_last"},  32'(b_out_last),  last);
  endtask

  // Send one 16-bit word with out_ready held high, then check its two bytes.
  task automatic word16(input string tag, input logic [15:0] w, input logic msb,
                        input logic [31:0] b0, input logic [31:0] l0,
                        input logic [31:0] b1, input logic [31:0] l1);
    @(negedge clk);
    a_in_valid = 1'b1; a_in_data = w; a_in_msb_first = msb; a_out_ready = 1'b1;
    #1 check({tag, "_accept_rdy"}, 32'(a_in_ready), 1);
    @(negedge clk);
    a_in_valid = 1'b0;
    #1 expect16({tag, "_b0"}, b0, l0, 0, 0);
    @(negedge clk);
    #1 expect16({tag, "_b1"}, b1, l1, 1, 1);
    @(negedge clk);
    #1 idle16({tag, "_end"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] msb_bytes [4];
    logic [31:0] lsb_bytes [4];
    msb_bytes = '{'hDE, 'hAD, 'hBE, 'hEF};
    lsb_bytes = '{'hEF, 'hBE, 'hAD, 'hDE};

    rst_n = 1'b0;
    a_in_valid = 1'b1; a_in_data = 16'hFFFF; a_in_msb_first = 1'b1; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0;       b_in_msb_first = 1'b0; b_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", 32'(a_in_ready),  0);
    check("rst_valid",    32'(a_out_valid), 0);
    check("rst_data",     32'(a_out_data),  0);
    check("rst_lane",     32'(a_out_lane),  0);
    check("rst_last",     32'(a_out_last),  0);
    check("rst_busy",     32'(a_busy),      0);
    check("rst_in_ready32", 32'(b_in_ready), 0);
    @(negedge clk);
    a_in_valid = 1'b0;
    rst_n = 1'b1;
    #1 idle16("post_rst");

    word16("msb", 16'hABCD, 1'b1, 'hAB, 1, 'hCD, 0);
    word16("lsb", 16'hABCD, 1'b0, 'hCD, 0, 'hAB, 1);

    // Backpressure: first byte held for four cycles.
    @(negedge clk);
    a_in_valid = 1'b1; a_in_data = 16'h1234; a_in_msb_first = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    #1 expect16("bp_hold0", 'h12, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1 expect16("bp_hold", 'h12, 1, 0, 0);
    end
    @(negedge clk);
    a_out_ready = 1'b1;
    #1 expect16("bp_hold3", 'h12, 1, 0, 0);
    @(negedge clk);
    #1 expect16("bp_b1", 'h34, 0, 1, 1);
    @(negedge clk);
    #1 idle16("bp_end");

    // Back-to-back words with in_valid held high.
    @(negedge clk);
    a_in_valid = 1'b1; a_in_data = 16'hABCD; a_in_msb_first = 1'b1;
    @(negedge clk);
    a_in_data = 16'h1234;
    #1 expect16("b2b_0", 'hAB, 1, 0, 0);
    @(negedge clk);
    #1 expect16("b2b_1", 'hCD, 0, 1, 1);
    @(negedge clk);
    a_in_valid = 1'b0;
    #1 expect16("b2b_2", 'h12, 1, 0, 0);
    @(negedge clk);
    #1 expect16("b2b_3", 'h34, 0, 1, 1);
    @(negedge clk);
    #1 idle16("b2b_end");

    // Reset mid-word: AB is showing, CD must never appear.
    @(negedge clk);
    a_in_valid = 1'b1; a_in_data = 16'hABCD; a_in_msb_first = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    #1 expect16("rstmid_b0", 'hAB, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_async_valid", 32'(a_out_valid), 0);
    check("rstmid_async_rdy",   32'(a_in_ready),  0);
    @(negedge clk);
    rst_n = 1'b1; a_out_ready = 1'b1;
    #1 idle16("rstmid_rel");
    check("rstmid_data", 32'(a_out_data), 0);
    @(negedge clk);
    #1 idle16("rstmid_nocd");
    word16("after_rst", 16'h5566, 1'b1, 'h55, 1, 'h66, 0);

    // 32-bit instance, MSB-first then LSB-first.
    @(negedge clk);
    b_in_valid = 1'b1; b_in_data = 32'hDEADBEEF; b_in_msb_first = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b_in_valid = 1'b0;
      #1 expect32($sformatf("w32_msb%0d", i), msb_bytes[i], 32'(3 - i), (i == 3) ? 1 : 0);
    end
    @(negedge clk);
    #1 check("w32_msb_end", 32'(b_out_valid), 0);
    b_in_valid = 1'b1; b_in_msb_first = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b_in_valid = 1'b0;
      #1 expect32($sformatf("w32_lsb%0d", i), lsb_bytes[i], 32'(i), (i == 3) ? 1 : 0);
    end
    @(negedge clk);
    #1 check("w32_lsb_end", 32'(b_out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/word_byte_serializer.md
Name: word_byte_serializer

Overview:
- Parametrised successor to the 16-to-8 byte-select mux.
- Accepts a DATA_W-bit word over a valid/ready handshake and emits it as DATA_W/BYTE_W bytes on the 8-bit internal bus, one byte per accepted beat.
- Lane order is selectable per word: MSB-first or LSB-first.
- Used where 16-bit (or wider) address/PC/immediate values must cross the 8-bit data bus, e.g. pushing the PC to the stack or driving the address latch.

Parameters:
- DATA_W, 16: input word width. Must be a multiple of BYTE_W and at least BYTE_W; otherwise elaboration fails.
- BYTE_W, 8: output lane width.
- LANES, DATA_W/BYTE_W: derived lane count. Not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  word available.
- in_ready  out  1  word can be accepted this cycle.
- in_data  in  DATA_W  word to serialise.
- in_msb_first  in  1  lane order for this word: 1 = high lane first, 0 = low lane first. Sampled with in_data.
- out_valid  out  1  out_data holds a valid byte.
- out_ready  in  1  consumer takes the byte this cycle.
- out_data  out  BYTE_W  current byte.
- out_lane  out  clog2(LANES), minimum 1  index of the lane in out_data. Lane k = in_data[k*BYTE_W +: BYTE_W].
- out_last  out  1  current byte is the final lane of the word.
- busy  out  1  word in flight (equals out_valid).

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE; out_valid=0; out_data=0; out_lane=0; out_last=0; busy=0.
  - Word register and order flag cleared.
  - in_ready is forced 0 while rst_n is low.
- Handshake:
  - Input accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - All outputs except in_ready are registered.
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last). This is combinational and allows zero-bubble back-to-back words.
- States:
  - IDLE: on input accept, latch in_data and in_msb_first, go to SEND.
  - SEND: hold the byte. On output transfer with !out_last, advance to the next lane. On output transfer with out_last, either accept the next word (stay in SEND, load its first lane) or, if no accept, go to IDLE.
- Latency:
  - Word accepted at edge N; first byte valid after edge N.
  - A word occupies exactly LANES transfer cycles under continuous out_ready.
  - Sustained throughput is one byte per cycle.
- Lane sequence:
  - MSB-first: LANES-1 down to 0.
  - LSB-first: 0 up to LANES-1.
  - out_last is set on lane 0 (MSB-first) or lane LANES-1 (LSB-first).
  - The lane counter never wraps past the last lane; lane selection is never out of range.
- Backpressure: while out_valid & !out_ready, out_data, out_lane and out_last remain stable, and in_ready=0 unless in IDLE.
- Order changes: in_msb_first may change between words; it is ignored mid-word.
- LANES==1: every byte has out_last=1 and out_lane=0; the block acts as a registered pipe stage.
- Reset mid-word: the partial word is discarded, out_valid drops immediately, and no byte from it appears after reset release.
- in_valid without in_ready: no state change. in_data may change freely until accepted.

Decomposition:
- Package cpu_bus_pkg holds:
  - BYTE_W=8 constant shared with the bus, ALU and register file.
  - Enum lane_order_t {LSB_FIRST=0, MSB_FIRST=1}.
  - State enum ser_state_t {IDLE, SEND}.
- Sub-module byte_lane_select: purely combinational, (word, lane index) -> BYTE_W slice, parametrised on DATA_W/BYTE_W. It is reusable by the matching deserialiser.

Test Plan:
- MSB-first word: DATA_W=16, in_data=0xABCD, in_msb_first=1, out_ready=1. Expect 0xAB (lane 1, last=0), then 0xCD (lane 0, last=1), then out_valid=0.
- LSB-first word: same word with in_msb_first=0. Expect 0xCD (lane 0), then 0xAB (lane 1, last=1).
- Backpressure: 0x1234 MSB-first, out_ready held low 3 cycles on the first byte. Expect 0x12 stable for 4 cycles and in_ready=0; then 0x34 with last=1.
- Back-to-back: 0xABCD then 0x1234, in_valid continuous, out_ready=1. Expect AB, CD, 12, 34 on 4 consecutive cycles; in_ready pulses high with each out_last.
- Wide instance: DATA_W=32, 0xDEADBEEF MSB-first. Expect DE, AD, BE, EF with lanes 3, 2, 1, 0. Then the same word LSB-first: EF, BE, AD, DE.
- Reset mid-word: assert rst_n low after byte 0xAB of 0xABCD. Expect out_valid=0 asynchronously and no 0xCD after release. The next word 0x5566 serialises cleanly as 55, 66.
